// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons: one shared
// decay/integrate/compare datapath walks the channels once per accepted timestep.
module lif_neuron_array #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int REFRAC_W = 4,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_valid,
  output logic                    step_ready,
  input  logic [N_CH*WIDTH-1:0]   current,
  input  logic [WIDTH-1:0]        threshold,
  input  logic [2:0]              leak_shift,
  input  logic                    reset_mode,
  input  logic [REFRAC_W-1:0]     refrac_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_CH-1:0]         spikes,
  input  logic [SEL_W-1:0]        mem_rd_sel,
  output logic [WIDTH-1:0]        mem_rd_data,
  output logic [CNT_W-1:0]        spike_total,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; step_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {IDLE = 2'd0, PROC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   NCH_L   = (SEL_W + 1)'(N_CH);

  state_t               state_q;
  logic [SEL_W-1:0]     ch_idx_q;
  logic [WIDTH-1:0]     cur_q [N_CH];
  logic [WIDTH-1:0]     mem_q [N_CH];
  logic [REFRAC_W-1:0]  ref_q [N_CH];
  logic [WIDTH-1:0]     thr_q;
  logic [2:0]           leak_q;
  logic                 mode_q;
  logic [REFRAC_W-1:0]  rlen_q;
  logic [N_CH-1:0]      spikes_q;
  logic [CNT_W-1:0]     total_q;
  logic                 step_ready_q;
  logic                 out_valid_q;

  logic [WIDTH-1:0]     cur_u;
  logic [REFRAC_W-1:0]  cur_r;
  logic [WIDTH-1:0]     cur_i;
  logic [WIDTH-1:0]     decay;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sat;
  logic                 in_refrac;
  logic                 fire;
  logic [WIDTH-1:0]     mem_d;
  logic [REFRAC_W-1:0]  ref_d;
  logic [CNT_W-1:0]     total_d;

  // Datapath for the channel currently selected by ch_idx_q.
  always_comb begin
    cur_u     = mem_q[ch_idx_q];
    cur_r     = ref_q[ch_idx_q];
    cur_i     = cur_q[ch_idx_q];
    decay     = (leak_q == 3'd0) ? cur_u : cur_u - (cur_u >> leak_q);
    sum       = {1'b0, decay} + {1'b0, cur_i};
    sat       = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    in_refrac = (cur_r != '0);
    fire      = !in_refrac && (sat >= thr_q);
    mem_d     = sat;
    ref_d     = '0;
    if (in_refrac) begin
      mem_d = decay;
      ref_d = cur_r - REFRAC_W'(1);
    end else if (fire) begin
      mem_d = mode_q ? sat - thr_q : '0;
      ref_d = rlen_q;
    end
    total_d = (fire && (total_q != '1)) ? total_q + CNT_W'(1) : total_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      ch_idx_q     <= '0;
      thr_q        <= '0;
      leak_q       <= '0;
      mode_q       <= 1'b0;
      rlen_q       <= '0;
      spikes_q     <= '0;
      total_q      <= '0;
      step_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cur_q[i] <= '0;
        mem_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (step_valid) begin
            for (int i = 0; i < N_CH; i++) cur_q[i] <= current[i*WIDTH +: WIDTH];
            thr_q        <= threshold;
            leak_q       <= leak_shift;
            mode_q       <= reset_mode;
            rlen_q       <= refrac_len;
            ch_idx_q     <= '0;
            spikes_q     <= '0;
            step_ready_q <= 1'b0;
            state_q      <= PROC;
          end
        end
        PROC: begin
          mem_q[ch_idx_q]    <= mem_d;
          ref_q[ch_idx_q]    <= ref_d;
          spikes_q[ch_idx_q] <= fire;
          total_q            <= total_d;
          if (ch_idx_q == LAST_CH) begin
            ch_idx_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            ch_idx_q <= ch_idx_q + SEL_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            step_ready_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          out_valid_q  <= 1'b0;
          step_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign step_ready  = step_ready_q;
  assign out_valid   = out_valid_q;
  assign spikes      = spikes_q;
  assign spike_total = total_q;
  assign state_dbg   = state_q;
  // Out-of-range selects (non power-of-two N_CH) read back as zero.
  assign mem_rd_data = ({1'b0, mem_rd_sel} < NCH_L) ? mem_q[mem_rd_sel] : '0;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: hand-computed spike vectors, membranes
// and counters across leak, reset-mode, refractory and handshake scenarios.
module tb_lif_neuron_array;

  logic        clk;
  logic        rst_n;
  logic        step_valid;
  logic        step_ready;
  logic [31:0] current;
  logic [7:0]  threshold;
  logic [2:0]  leak_shift;
  logic        reset_mode;
  logic [3:0]  refrac_len;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  spikes;
  logic [1:0]  mem_rd_sel;
  logic [7:0]  mem_rd_data;
  logic [15:0] spike_total;
  logic [1:0]  state_dbg;

  int n_vec  = 0;
  int n_miss = 0;
  logic [3:0] exp_q[$];

  lif_neuron_array #(
    .N_CH(4), .WIDTH(8), .REFRAC_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .step_valid(step_valid), .step_ready(step_ready),
    .current(current), .threshold(threshold), .leak_shift(leak_shift),
    .reset_mode(reset_mode), .refrac_len(refrac_len),
    .out_valid(out_valid), .out_ready(out_ready), .spikes(spikes),
    .mem_rd_sel(mem_rd_sel), .mem_rd_data(mem_rd_data),
    .spike_total(spike_total), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic mem_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    mem_rd_sel = sel;
    #1;
    check(tag, {24'd0, mem_rd_data}, {24'd0, exp});
  endtask

  // Driver: one timestep, inputs scrambled right after accept to prove latching.
  task automatic do_step(input logic [31:0] cur, input logic [7:0] thr, input logic [2:0] lk,
                         input logic md, input logic [3:0] rl, input logic [3:0] exp_sp);
    bit ok;
    logic [3:0] e;
    exp_q.push_back(exp_sp);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("step_ready_timeout", 32'd0, 32'd1);
    current = cur; threshold = thr; leak_shift = lk; reset_mode = md; refrac_len = rl;
    step_valid = 1'b1;
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    current    = 32'hA5A5_A5A5;
    threshold  = ~thr;
    leak_shift = ~lk;
    reset_mode = ~md;
    refrac_len = ~rl;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
    e = exp_q.pop_front();
    check("spikes", {28'd0, spikes}, {28'd0, e});
  endtask

  initial begin
    rst_n = 1'b1; step_valid = 1'b0; current = '0; threshold = '0; leak_shift = '0;
    reset_mode = 1'b0; refrac_len = '0; out_ready = 1'b1; mem_rd_sel = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_step_ready", {31'd0, step_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_spikes", {28'd0, spikes}, 32'd0);
    check("rst_total", {16'd0, spike_total}, 32'd0);
    for (int c = 0; c < 4; c++) mem_chk("rst_mem", 2'(c), 8'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // No leak, zero mode, saturation on third step
    do_step(32'h0000_0064, 8'd230, 3'd0, 1'b0, 4'd0, 4'b0000);
    mem_chk("sat_u0_s1", 2'd0, 8'd100);
    do_step(32'h0000_0064, 8'd230, 3'd0, 1'b0, 4'd0, 4'b0000);
    mem_chk("sat_u0_s2", 2'd0, 8'd200);
    do_step(32'h0000_0064, 8'd230, 3'd0, 1'b0, 4'd0, 4'b0001);
    mem_chk("sat_u0_s3", 2'd0, 8'd0);
    check("sat_total", {16'd0, spike_total}, 32'd1);

    // Subtract-threshold mode
    apply_reset();
    do_step(32'h0000_9600, 8'd100, 3'd0, 1'b1, 4'd0, 4'b0010);
    mem_chk("sub_u1_s1", 2'd1, 8'd50);
    do_step(32'h0000_9600, 8'd100, 3'd0, 1'b1, 4'd0, 4'b0010);
    mem_chk("sub_u1_s2", 2'd1, 8'd100);
    do_step(32'h0000_9600, 8'd100, 3'd0, 1'b1, 4'd0, 4'b0010);
    mem_chk("sub_u1_s3", 2'd1, 8'd150);
    check("sub_total", {16'd0, spike_total}, 32'd3);

    // Leak by shift of 1
    apply_reset();
    do_step(32'hC800_0000, 8'd255, 3'd1, 1'b0, 4'd0, 4'b0000);
    mem_chk("leak_u3_s1", 2'd3, 8'd200);
    do_step(32'h0000_0000, 8'd255, 3'd1, 1'b0, 4'd0, 4'b0000);
    mem_chk("leak_u3_s2", 2'd3, 8'd100);
    do_step(32'h0000_0000, 8'd255, 3'd1, 1'b0, 4'd0, 4'b0000);
    mem_chk("leak_u3_s3", 2'd3, 8'd50);
    do_step(32'h0000_0000, 8'd255, 3'd1, 1'b0, 4'd0, 4'b0000);
    mem_chk("leak_u3_s4", 2'd3, 8'd25);
    check("leak_total", {16'd0, spike_total}, 32'd0);

    // Refractory period of 2 steps
    apply_reset();
    do_step(32'h003C_0000, 8'd50, 3'd0, 1'b0, 4'd2, 4'b0100);
    mem_chk("ref_u2_s1", 2'd2, 8'd0);
    do_step(32'h003C_0000, 8'd50, 3'd0, 1'b0, 4'd2, 4'b0000);
    mem_chk("ref_u2_s2", 2'd2, 8'd0);
    do_step(32'h003C_0000, 8'd50, 3'd0, 1'b0, 4'd2, 4'b0000);
    mem_chk("ref_u2_s3", 2'd2, 8'd0);
    do_step(32'h003C_0000, 8'd50, 3'd0, 1'b0, 4'd2, 4'b0100);
    mem_chk("ref_u2_s4", 2'd2, 8'd0);
    check("ref_total", {16'd0, spike_total}, 32'd2);

    // Zero threshold: every channel fires
    apply_reset();
    do_step(32'h0000_0000, 8'd0, 3'd0, 1'b0, 4'd0, 4'b1111);
    check("thr0_total", {16'd0, spike_total}, 32'd4);

    // Back-pressure in DONE, ignored step_valid pulse
    apply_reset();
    out_ready = 1'b0;
    do_step(32'h0000_000A, 8'd5, 3'd0, 1'b1, 4'd0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_spikes", {28'd0, spikes}, 32'd1);
      check("hold_step_ready", {31'd0, step_ready}, 32'd0);
      if (i == 1) step_valid = 1'b1;
      if (i == 2) step_valid = 1'b0;
      @(negedge clk);
    end
    step_valid = 1'b0;
    mem_chk("hold_u0", 2'd0, 8'd5);
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("rel_step_ready", {31'd0, step_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("idle_step_ready", {31'd0, step_ready}, 32'd1);
    check("idle_total", {16'd0, spike_total}, 32'd1);
    mem_chk("idle_u0", 2'd0, 8'd5);

    // Asynchronous reset in the second PROC cycle
    apply_reset();
    @(negedge clk);
    current = 32'h0000_000A; threshold = 8'd5; leak_shift = '0; reset_mode = 1'b1;
    refrac_len = '0; step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    @(posedge clk);
    #2;
    mem_chk("arst_pre_u0", 2'd0, 8'd5);
    check("arst_pre_total", {16'd0, spike_total}, 32'd1);
    rst_n = 1'b1;
    #1;
    check("arst_step_ready", {31'd0, step_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_spikes", {28'd0, spikes}, 32'd0);
    check("arst_total", {16'd0, spike_total}, 32'd0);
    mem_chk("arst_u0", 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (8) @(negedge clk);
    check("arst_idle_valid", {31'd0, out_valid}, 32'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N_CH leaky integrate-and-fire neurons sharing one integrate/compare datapath. Each accepted timestep latches one input current per channel and the configuration, then updates channels one per cycle. It presents the resulting spike vector on a valid/ready output handshake. It is the parametrised successor to the single fixed-width IF neuron: it adds configurable width, leak, reset mode, refractory period and channel count.

## Interface
- N_CH, 4: number of neuron channels (≥1)
- WIDTH, 8: membrane/current/threshold width
- REFRAC_W, 4: refractory counter width
- CNT_W, 16: total spike counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-high (1 = reset asserted)
- step_valid  in  1  timestep request
- step_ready  out  1  block idle, can accept timestep
- current  in  N_CH*WIDTH  channel i current at bits [i*WIDTH +: WIDTH], latched on accept
- threshold  in  WIDTH  spike threshold, latched on accept
- leak_shift  in  3  decay: 0 = none, k = U − (U>>k), latched on accept
- reset_mode  in  1  0 = reset-to-zero, 1 = subtract threshold, latched on accept
- refrac_len  in  REFRAC_W  refractory steps after a spike, latched on accept
- out_valid  out  1  spike vector valid
- out_ready  in  1  consumer accepts spike vector
- spikes  out  N_CH  spike bit per channel for last completed step
- mem_rd_sel  in  clog2(N_CH)  membrane read select
- mem_rd_data  out  WIDTH  combinational read of membrane[mem_rd_sel]
- spike_total  out  CNT_W  saturating count of all spikes since reset

## Operation
- FSM states: IDLE, PROC, DONE. Reset enters IDLE.
- IDLE: step_ready=1. step_valid&step_ready at an edge latches current and config, sets ch_idx=0, and moves to PROC.
- PROC: step_ready=0. Each cycle updates channel ch_idx and increments it. The update of ch_idx=N_CH−1 moves to DONE.
- DONE: out_valid=1, spikes stable. out_valid&out_ready at an edge moves to IDLE. step_valid is ignored outside IDLE.
- Per-channel update, with U = membrane and R = refractory counter:
  - Decay: D = (leak_shift==0) ? U : U − (U>>leak_shift).
  - If R≠0: U←D, R←R−1, spike=0. Input current is ignored.
  - Otherwise S = D + I, computed in WIDTH+1 bits and saturated to 2^WIDTH−1.
  - spike = (S ≥ threshold).
  - On spike: U ← reset_mode ? S−threshold : 0, and R ← refrac_len.
  - No spike: U ← S.
- The spikes[i] register is written in the channel's PROC cycle. The whole vector is cleared on PROC entry.
- spike_total increments by 1 per spike, in the same cycle as the channel update, and saturates at 2^CNT_W−1.
- threshold=0 makes every non-refractory channel spike.
- Config or current changes after accept have no effect until the next accept.

## Timing
- Reset values: step_ready=1, out_valid=0, spikes=0, spike_total=0, all U=0, all R=0, FSM=IDLE, ch_idx=0.
- Reset is asynchronous: asserting rst_n mid-PROC or mid-DONE clears all state immediately, and the partial step is discarded.
- Accept at edge T. Channel i is updated at edge T+1+i. out_valid rises after edge T+N_CH.
- With out_ready held at 1, DONE lasts one cycle. Peak throughput is one step per N_CH+2 cycles.
- mem_rd_data is combinational from the membrane register, so it reflects an update the cycle after the channel's update edge.
- While out_ready=0: out_valid, spikes and all membranes are held, and no new step is accepted.

## Test plan
- Reset: hold rst_n=1 across any edge. Required: step_ready=1, out_valid=0, spikes=0, spike_total=0, mem_rd_data=0 for every channel.
- No leak, zero mode, threshold=230, ch0 current=100, other channels 0, three steps. Required:
  - Step 1: U0=100, spikes=0000.
  - Step 2: U0=200, spikes=0000.
  - Step 3: S saturates at 255, spikes=0001, U0=0, spike_total=1.
- Subtract mode, threshold=100, ch1 current=150, three steps. Required: spikes=0010 every step, U1 = 50, then 100, then 150, spike_total=3.
- leak_shift=1, threshold=255, ch3 current=200 for one step, then current=0. Required: U3 = 200, then 100, then 50, then 25, and no spikes.
- refrac_len=2, zero mode, threshold=50, ch2 current=60, four steps. Required: spikes[2] = 1, 0, 0, 1, and U2 = 0, 0, 0, 0.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE. Required: out_valid and spikes stable, step_ready=0, and a step_valid pulse is not accepted.
  - Assert rst_n in the 2nd PROC cycle. Required: same-cycle return to reset values.
